// File: rtl/led_runner_pkg.sv
// led_runner_pkg: shared state type and counter width helper for the running-light driver
package led_runner_pkg;
  typedef enum logic {UP, DOWN} run_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_runner_tick_prescaler.sv
// tick_prescaler: one-cycle tick every PRESCALE clocks, reusable by any button stage
module tick_prescaler
  import led_runner_pkg::*;
#(
  parameter int PRESCALE = 26214
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int PW = cw(PRESCALE);
  logic [PW-1:0] presc;
  assign tick = presc == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc <= '0;
    else presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/led_runner.sv
// led_runner: bouncing (or, with LED_RUNNER_WRAP_EN, wrapping) lit bar of width 1 or WIDE
// across N_LED outputs; also supplies the shared rtg_tick sample strobe.
module led_runner
  import led_runner_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int WIDE     = 3,
  parameter int PRESCALE = 26214,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_flag,
  input  logic             size_flag,
  output logic             rtg_tick,
  output logic [N_LED-1:0] led,
  output logic             dir
);
  localparam int PW = cw(N_LED);
  localparam int DW = cw(STEP_DIV);
  logic size_q, step, div_end;
  logic [DW-1:0] div;
  logic [PW-1:0] pos, pos_n;
  run_state_t state, state_n;
  int w, p;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (.clk(clk), .rst_n(rst_n), .tick(rtg_tick));
  assign w = size_q ? WIDE : 1;
  assign p = int'(pos);
  assign div_end = div == DW'(STEP_DIV - 1);
  assign step = run_flag & rtg_tick & div_end;
  assign dir = state == DOWN;
`ifdef LED_RUNNER_WRAP_EN
  always_comb begin
    state_n = UP;
    pos_n = step ? (p == N_LED - 1 ? '0 : pos + 1'b1) : pos;
  end
  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) led[i] = ((i - p + N_LED) % N_LED) < w;
  end
`else
  logic clamp;
  // A widening bar that would overrun the MSB is pulled back; this wins over a step.
  assign clamp = size_flag & ~size_q & (p > N_LED - WIDE);
  always_comb begin
    pos_n = pos;
    state_n = state;
    if (clamp) pos_n = PW'(N_LED - WIDE);
    else if (step && state == UP) begin
      pos_n = p < N_LED - w ? pos + 1'b1 : pos - 1'b1;
      state_n = p < N_LED - w ? UP : DOWN;
    end else if (step) begin
      pos_n = p > 0 ? pos - 1'b1 : pos + 1'b1;
      state_n = p > 0 ? DOWN : UP;
    end
  end
  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) led[i] = i >= p && i < p + w;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      size_q <= 1'b0;
      div <= '0;
      pos <= '0;
      state <= UP;
    end else begin
      size_q <= size_flag;
      div <= !run_flag ? '0 : rtg_tick ? (div_end ? '0 : div + 1'b1) : div;
      pos <= pos_n;
      state <= state_n;
    end
endmodule

// File: tb/tb_led_runner.sv
// tb_led_runner: directed checks of the bounce build with N_LED=8, WIDE=3, PRESCALE=4, STEP_DIV=2
module tb_led_runner;
  logic clk = 1'b0, rst_n = 1'b0, run_flag = 1'b0, size_flag = 1'b0;
  logic rtg_tick, dir;
  logic [7:0] led;
  int vecs = 0, errs = 0;
  led_runner #(.N_LED(8), .WIDE(3), .PRESCALE(4), .STEP_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .run_flag(run_flag), .size_flag(size_flag),
    .rtg_tick(rtg_tick), .led(led), .dir(dir)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    cyc(2);
    vecs++; if (led !== 8'h01) begin errs++; $display("FAIL reset_led got %h want 01", led); end
    vecs++; if (dir !== 1'b0) begin errs++; $display("FAIL reset_dir got %b want 0", dir); end
    vecs++; if (rtg_tick !== 1'b0) begin errs++; $display("FAIL reset_tick got %b want 0", rtg_tick); end
    rst_n = 1'b1;
  endtask
  task automatic test_prescale;
    run_flag = 1'b1;
    cyc(3);
    vecs++; if (rtg_tick !== 1'b1) begin errs++; $display("FAIL tick_c3 got %b want 1", rtg_tick); end
    cyc(1);
    vecs++; if (rtg_tick !== 1'b0) begin errs++; $display("FAIL tick_c4 got %b want 0", rtg_tick); end
    cyc(3);
    vecs++; if (rtg_tick !== 1'b1 || led !== 8'h01) begin errs++; $display("FAIL tick_c7 got tick=%b led=%h want 1/01", rtg_tick, led); end
    cyc(1);
    vecs++; if (led !== 8'h02) begin errs++; $display("FAIL first_step got %h want 02", led); end
    cyc(8);
    vecs++; if (led !== 8'h04) begin errs++; $display("FAIL second_step got %h want 04", led); end
  endtask
  task automatic test_bounce;
    logic [7:0] up_exp [5] = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] dn_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       dn_dir [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(8);
      vecs++; if (led !== up_exp[i] || dir !== 1'b0) begin errs++; $display("FAIL bounce_up[%0d] got %h/%b want %h/0", i, led, dir, up_exp[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(8);
      vecs++; if (led !== dn_exp[i] || dir !== dn_dir[i]) begin errs++; $display("FAIL bounce_dn[%0d] got %h/%b want %h/%b", i, led, dir, dn_exp[i], dn_dir[i]); end
    end
  endtask
  task automatic test_grow;
    logic [7:0] g_exp [10] = '{8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};
    logic       g_dir [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    cyc(40);
    vecs++; if (led !== 8'h40) begin errs++; $display("FAIL pre_grow got %h want 40", led); end
    size_flag = 1'b1;
    cyc(1);
    vecs++; if (led !== 8'hE0 || dir !== 1'b0) begin errs++; $display("FAIL clamp got %h/%b want e0/0", led, dir); end
    cyc(7);
    vecs++; if (led !== 8'h70 || dir !== 1'b1) begin errs++; $display("FAIL wide_turn got %h/%b want 70/1", led, dir); end
    for (int i = 0; i < 10; i++) begin
      cyc(8);
      vecs++; if (led !== g_exp[i] || dir !== g_dir[i]) begin errs++; $display("FAIL wide[%0d] got %h/%b want %h/%b", i, led, dir, g_exp[i], g_dir[i]); end
    end
    size_flag = 1'b0;
    cyc(1);
    vecs++; if (led !== 8'h10 || dir !== 1'b1) begin errs++; $display("FAIL shrink got %h/%b want 10/1", led, dir); end
    cyc(7);
    vecs++; if (led !== 8'h08 || dir !== 1'b1) begin errs++; $display("FAIL post_shrink got %h/%b want 08/1", led, dir); end
  endtask
  task automatic test_freeze;
    run_flag = 1'b0;
    cyc(3);
    vecs++; if (rtg_tick !== 1'b1 || led !== 8'h08) begin errs++; $display("FAIL frozen_tick got %b/%h want 1/08", rtg_tick, led); end
    cyc(13);
    vecs++; if (led !== 8'h08 || dir !== 1'b1) begin errs++; $display("FAIL frozen got %h/%b want 08/1", led, dir); end
    run_flag = 1'b1;
    cyc(7);
    vecs++; if (rtg_tick !== 1'b1 || led !== 8'h08) begin errs++; $display("FAIL resume_wait got %b/%h want 1/08", rtg_tick, led); end
    cyc(1);
    vecs++; if (led !== 8'h04 || dir !== 1'b1) begin errs++; $display("FAIL resume_step got %h/%b want 04/1", led, dir); end
  endtask
  task automatic test_reset_mid;
    cyc(3);
    vecs++; if (rtg_tick !== 1'b1) begin errs++; $display("FAIL pre_rst_tick got %b want 1", rtg_tick); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (led !== 8'h01 || dir !== 1'b0 || rtg_tick !== 1'b0) begin errs++; $display("FAIL async_rst got %h/%b/%b want 01/0/0", led, dir, rtg_tick); end
    rst_n = 1'b1;
    cyc(2);
    vecs++; if (rtg_tick !== 1'b0) begin errs++; $display("FAIL post_rst_c2 got %b want 0", rtg_tick); end
    cyc(1);
    vecs++; if (rtg_tick !== 1'b1 || led !== 8'h01) begin errs++; $display("FAIL post_rst_c3 got %b/%h want 1/01", rtg_tick, led); end
  endtask
  initial begin
    test_reset;
    test_prescale;
    test_bounce;
    test_grow;
    test_freeze;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
